// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_pkg
//  Description : Shared state encoding and default width for the bit-serial
//                addition sequencer.
//  Revision    : 1.0
// ============================================================================
package serial_add_pkg;

    localparam int SA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/fulladd.sv
`default_nettype none
// ============================================================================
//  Module      : fulladd
//  Description : Single-bit full adder cell.
//  Revision    : 1.0
// ============================================================================
module fulladd (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_cin;
    assign o_c = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : fulladd
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder sequencer; one shared full adder processes
//                one operand bit per tick, LSB first, sum built up MSB-side.
//  Revision    : 1.0
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       start,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic [WIDTH-1:0]           sum,
    output logic                       cout,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bits_done
);

    localparam int                  c_bw   = $clog2(WIDTH+1);
    localparam logic [c_bw-1:0]     c_last = c_bw'(WIDTH-1);

    sa_state_t          r_state;
    sa_state_t          w_state_nxt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [c_bw-1:0]    r_bits;
    logic               w_fa_s;
    logic               w_fa_c;
    logic               w_load;
    logic               w_step;

    fulladd u_fulladd (
        .i_a   (r_op_a[0]),
        .i_b   (r_op_b[0]),
        .i_cin (r_carry),
        .o_s   (w_fa_s),
        .o_c   (w_fa_c)
    );

    // clear dominates both a new start and a pending step
    assign w_load = !clear && start && ((r_state == IDLE) || (r_state == DONE));
    assign w_step = !clear && tick && (r_state == SHIFT);

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_nxt = SHIFT;
                SHIFT:   if (tick && (r_bits == c_last)) w_state_nxt = DONE;
                DONE:    if (start) w_state_nxt = SHIFT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_bits  <= '0;
        end else if (clear) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_bits  <= '0;
        end else if (w_load) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_bits  <= '0;
        end else if (w_step) begin
            r_op_a  <= {1'b0, r_op_a[WIDTH-1:1]};
            r_op_b  <= {1'b0, r_op_b[WIDTH-1:1]};
            r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
            r_carry <= w_fa_c;
            r_bits  <= r_bits + c_bw'(1);
        end
    end

    assign sum       = r_sum;
    assign cout      = r_carry;
    assign bits_done = r_bits;
    assign busy      = (r_state == SHIFT);
    assign done      = (r_state == DONE);

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Scoreboard bench for serial_add_ctrl against an arithmetic
//                reference model.
//  Revision    : 1.0
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W  = 8;
    localparam int BW = $clog2(W+1);

    logic          clk;
    logic          reset;
    logic          tick;
    logic          start;
    logic          clear;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;
    logic          done;
    logic [BW-1:0] bits_done;

    int n_pass  = 0;
    int n_total = 0;

    // expected full (W+1)-bit result of each launched operation
    logic [W:0] sb_q[$];
    logic       prev_done = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .clear     (clear),
        .a         (a_i),
        .b         (b_i),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .done      (done),
        .bits_done (bits_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // top k bits of sum hold the low k bits of a+b
    function automatic int model_partial_sum(input int a, input int b, input int k);
        int low;
        low = (a + b) % (1 << k);
        return (low << (W - k)) & ((1 << W) - 1);
    endfunction

    function automatic int model_partial_carry(input int a, input int b, input int k);
        return ((a % (1 << k)) + (b % (1 << k))) >> k;
    endfunction

    // monitor: every rising edge of done retires one scoreboard entry
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                logic [W:0] e;
                e = sb_q.pop_front();
                chk("sb_sum", int'(sum), int'(e[W-1:0]));
                chk("sb_cout", int'(cout), int'(e[W]));
                chk("sb_bits_done", int'(bits_done), W);
            end
        end
        prev_done = done;
    end

    // launch one op; period=1 means tick held high, else one tick every period cycles
    task automatic run_op(input int a, input int b, input int period,
                          input bit partial, input int poke_at);
        int cyc;
        int ticks;
        a_i   = W'(a);
        b_i   = W'(b);
        start = 1'b1;
        tick  = (period == 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_q.push_back((W+1)'(a + b));
        chk("busy_after_start", int'(busy), 1);
        cyc   = 0;
        ticks = 0;
        while (!done && cyc < 200) begin
            tick  = (period == 1) ? 1'b1 : ((cyc % period) == period - 1);
            if (cyc == poke_at) begin
                start = 1'b1;
                a_i   = W'($urandom);
                b_i   = W'($urandom);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (tick) begin
                ticks++;
                if (partial) begin
                    chk("partial_sum", int'(sum), model_partial_sum(a, b, ticks));
                    chk("partial_cout", int'(cout), model_partial_carry(a, b, ticks));
                    chk("partial_bits", int'(bits_done), ticks);
                end
            end
            cyc++;
        end
        tick = 1'b0;
        chk("op_timeout", int'(cyc < 200), 1);
        chk("ticks_to_done", ticks, W);
        if (period == 1) chk("latency_cycles", cyc, W);
        chk("done_level", int'(done), 1);
        chk("busy_in_done", int'(busy), 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sum"},  int'(sum), 0);
        chk({tag, "_cout"}, int'(cout), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_bits"}, int'(bits_done), 0);
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        a_i   = '0;
        b_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // directed operations
        run_op(8'h5A, 8'h3C, 1, 1'b1, -1);
        chk("basic_sum", int'(sum), 8'h96);
        run_op(8'hFF, 8'h01, 1, 1'b1, -1);
        chk("ripple_sum", int'(sum), 8'h00);
        chk("ripple_cout", int'(cout), 1);
        run_op(8'hFF, 8'hFF, 1, 1'b0, -1);
        chk("ff_ff_sum", int'(sum), 8'hFE);
        run_op(8'h12, 8'h34, 4, 1'b1, -1);
        chk("sparse_sum", int'(sum), 8'h46);

        // ticks while in DONE leave the result alone
        tick = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tick = 1'b0;
        chk("done_hold_sum", int'(sum), 8'h46);
        chk("done_hold_done", int'(done), 1);
        chk("done_hold_bits", int'(bits_done), W);

        // start during SHIFT must not disturb the operation
        run_op(8'h5A, 8'h3C, 1, 1'b1, 3);
        chk("start_in_shift_sum", int'(sum), 8'h96);

        // start together with clear in DONE: clear wins
        a_i   = 8'h77;
        b_i   = 8'h11;
        start = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        chk_idle("start_clear");

        // clear mid-SHIFT aborts back to IDLE
        a_i   = 8'hA5;
        b_i   = 8'h5A;
        start = 1'b1;
        tick  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        tick  = 1'b0;
        chk_idle("clear_mid");

        // asynchronous reset after 3 bits
        a_i   = 8'hC3;
        b_i   = 8'h3D;
        start = 1'b1;
        tick  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_q.push_back(9'(8'hC3 + 8'h3D));
        repeat (3) @(posedge clk);
        #1;
        tick = 1'b0;
        chk("pre_reset_bits", int'(bits_done), 3);
        chk("pre_reset_sum", int'(sum), model_partial_sum(8'hC3, 8'h3D, 3));
        #2;
        reset = 1'b1;
        #1;
        void'(sb_q.pop_back());
        chk_idle("async_reset");
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tick = 1'b0;
        chk_idle("wait_after_reset");
        run_op(8'h01, 8'h01, 1, 1'b1, -1);
        chk("post_reset_sum", int'(sum), 8'h02);

        // randomized operations, launched back-to-back from DONE
        for (int i = 0; i < 20; i++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(1, 4)), 1'b1, -1);
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire
